// File: rtl/upsample_multi_nn_pkg.sv
// Shared definitions for the multi-channel nearest-neighbour upsampler:
// FSM encoding and channel-slice width helpers.
package upsample_multi_nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } us_state_e;

  // Bits occupied by one input channel map.
  function automatic int in_slice_w(input int h, input int w, input int dw);
    return h * w * dw;
  endfunction

  // Bits occupied by one upsampled output channel map.
  function automatic int out_slice_w(input int h, input int w, input int s, input int dw);
    return h * s * w * s * dw;
  endfunction

endpackage

// File: rtl/upsample_single_nn.sv
// Combinational single-channel nearest-neighbour expander: out(Y,X) = in(Y/S, X/S).
// Element 0 sits at the MSB end of each flat vector.
module upsample_single_nn #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 13,
  parameter int W          = 13,
  parameter int S          = 2
) (
  input  logic [0:H*W*DATA_WIDTH-1]     ch_in,
  output logic [0:H*S*W*S*DATA_WIDTH-1] ch_out
);

  for (genvar y = 0; y < H*S; y++) begin : g_row
    for (genvar x = 0; x < W*S; x++) begin : g_col
      assign ch_out[(y*W*S + x)*DATA_WIDTH +: DATA_WIDTH] =
        ch_in[((y/S)*W + x/S)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/upsample_multi_nn.sv
// Multi-channel nearest-neighbour upsampler: latches all channels on start, then
// expands one channel per clock into the registered output through a shared expander.
module upsample_multi_nn
  import upsample_multi_nn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 2,
  parameter int H          = 13,
  parameter int W          = 13,
  parameter int S          = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              usStart,
  input  logic [0:H*W*D*DATA_WIDTH-1]       usInput,
  output logic [0:H*S*W*S*D*DATA_WIDTH-1]   usOutput,
  output logic                              usBusy,
  output logic                              usDone
);

  localparam int CW     = $clog2(D) + 1;
  localparam int IN_CW  = in_slice_w(H, W, DATA_WIDTH);
  localparam int OUT_CW = out_slice_w(H, W, S, DATA_WIDTH);

  us_state_e             state, state_nxt;
  logic [CW-1:0]         counter;
  logic [0:IN_CW*D-1]    in_reg;
  logic [0:IN_CW-1]      ch_in;
  logic [0:OUT_CW-1]     ch_out;
  logic                  last_ch;

  assign last_ch = (counter == CW'(D-1));
  assign ch_in   = in_reg[int'(counter)*IN_CW +: IN_CW];

  upsample_single_nn #(
    .DATA_WIDTH (DATA_WIDTH),
    .H          (H),
    .W          (W),
    .S          (S)
  ) u_expand (
    .ch_in  (ch_in),
    .ch_out (ch_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (usStart) state_nxt = ST_RUN;
      ST_RUN:  if (last_ch) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Only the IDLE state samples usStart, so a start during RUN/DONE is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      counter  <= '0;
      in_reg   <= '0;
      usOutput <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (usStart) begin
          in_reg  <= usInput;
          counter <= '0;
        end
        ST_RUN: begin
          usOutput[int'(counter)*OUT_CW +: OUT_CW] <= ch_out;
          counter <= counter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign usBusy = (state != ST_IDLE);
  assign usDone = (state == ST_DONE);

endmodule
